booth_seq_mult_ctrl: RTL and testbench
======================================

// Module: booth_seq_mult_ctrl
// PURPOSE
//   Sequential radix-2 Booth multiplier controller with its shift/add datapath.
//   Accepts operands A and B from the keypad entry FSM on a one-cycle start pulse.
//   Iterates one Booth step per clock and presents a 2*WIDTH-bit product with a done/ack handshake.
//   Sits between the operand-entry FSM and the result display/BCD conversion stage.
// PARAMETERS
//   WIDTH  8  operand width in bits; signed two's complement unless BOOTH_UNSIGNED_EN is defined
// PORTS
//   clk         in   1        system clock, rising edge
//   rst         in   1        asynchronous, active-low reset
//   start       in   1        1-cycle pulse; operands valid on this cycle (driven by entry FSM ready)
//   op_a        in   WIDTH    multiplicand M, sampled only when start is accepted
//   op_b        in   WIDTH    multiplier Q, sampled only when start is accepted
//   result_ack  in   1        consumer has taken product; releases DONE
//   busy        out  1        high in CALC
//   done        out  1        high in DONE; product valid while high
//   product     out  2*WIDTH  A*B; held stable while done=1
// BEHAVIOUR
//   Reset (async, rst=0): state=IDLE; busy=0, done=0, product=0; acc, Q, q_m1, count all cleared.
//   Reset mid-CALC aborts immediately; no partial result is ever flagged done.
//   States: IDLE -> CALC -> DONE -> (IDLE | CALC). 2-bit encoding; illegal state -> IDLE.
//   IDLE: on start=1 at edge t0: M<=op_a, Q<=op_b, acc<=0, q_m1<=0, count<=N, state<=CALC.
//   CALC: each edge executes one Booth step on {Q[0],q_m1}:
//     01: acc<=acc+M (sign-extended).  10: acc<=acc-M.  00/11: no add.
//     Then arithmetic right shift of {acc,Q,q_m1} by 1 (acc MSB replicated). count<=count-1.
//   acc is WIDTH+1 bits internally, so that acc-M with M=-2^(WIDTH-1) does not overflow.
//   When the step with count==1 executes: product<={acc,Q}[2*WIDTH-1:0], done<=1, state<=DONE.
//   Latency: done rises at edge t0+N, i.e. N cycles after the start edge. N=WIDTH (signed).
//   busy=1 exactly for states CALC (N cycles); busy and done are never high together.
//   start while in CALC is ignored; operands are not re-sampled.
//   DONE: done and product held until result_ack=1 -> IDLE (done<=0 next edge, product retained).
//   start in DONE is accepted as in IDLE: done<=0, new operands loaded, state<=CALC.
//   start and result_ack together in DONE: start wins; behaves as start alone.
//   result_ack outside DONE: ignored.
//   count width is $clog2(WIDTH+2); count never wraps, CALC exits on count==1.
// CONFIGURATION
//   BOOTH_UNSIGNED_EN undefined: operands signed two's complement; N=WIDTH iterations.
//   BOOTH_UNSIGNED_EN defined: op_a and op_b zero-extended to WIDTH+1 bits; N=WIDTH+1 iterations.
//     product = low 2*WIDTH bits of the unsigned result; latency WIDTH+1; all else identical.
// TESTING (WIDTH=8)
//   start with A=3, B=5 -> busy for 8 cycles, done at t0+8, product=0x000F; hold until ack.
//   A=-7 (0xF9), B=6 -> product=0xFFD6 (-42). A=-128, B=-128 -> product=0x4000 (16384).
//   A=127, B=-128 -> product=0xC080 (-16256).
//   A=0, B=-1 -> product=0x0000, done at t0+8.
//   start pulse mid-CALC with A=9, B=9 -> ignored; first result unchanged.
//   rst low at CALC cycle 4 -> busy=0, done=0, product=0 immediately.
//   Next start computes correctly.
//   In DONE, assert start+result_ack same cycle with A=2, B=2 -> new CALC; done=1 at +8 with 0x0004.
//   BOOTH_UNSIGNED_EN defined: A=255, B=255 -> done at t0+9, product=0xFE01.

Source files
------------

// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-2 Booth multiplier: one step per clock, product held under a done/ack handshake.
// Optional BOOTH_UNSIGNED_EN: zero-extended operands and one extra iteration for unsigned products.
module booth_seq_mult_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   input  logic                 result_ack,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_UNSIGNED_EN
   localparam int OPW = WIDTH + 1;
`else
   localparam int OPW = WIDTH;
`endif
   localparam int AW = OPW + 1;
   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] N_ITER = CW'(OPW);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t state, state_nxt;

   logic [OPW-1:0]     m_reg, q_reg;
   logic [AW-1:0]      acc;
   logic               q_m1;
   logic [CW-1:0]      count;

   logic [OPW-1:0]     a_ext, b_ext;
   logic [AW-1:0]      m_ext, sum, acc_n;
   logic [OPW-1:0]     q_n;
   logic [2*WIDTH-1:0] product_n;
   logic               load;

   always_comb begin
`ifdef BOOTH_UNSIGNED_EN
      a_ext = {1'b0, op_a};
      b_ext = {1'b0, op_b};
`else
      a_ext = op_a;
      b_ext = op_b;
`endif
   end

   // Entering CALC from DONE is a fresh load just like from IDLE
   assign load = start && ((state == S_IDLE) || (state == S_DONE));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE: state_nxt = start ? S_CALC : S_IDLE;
         S_CALC: state_nxt = (count == CW'(1)) ? S_DONE : S_CALC;
         S_DONE: begin
            if (start)           state_nxt = S_CALC;
            else if (result_ack) state_nxt = S_IDLE;
            else                 state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_CALC:  busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // One Booth step: conditional add/subtract, then arithmetic shift of {acc,Q,q_m1}
   always_comb begin
      m_ext = {m_reg[OPW-1], m_reg};
      case ({q_reg[0], q_m1})
         2'b01:   sum = acc + m_ext;
         2'b10:   sum = acc - m_ext;
         default: sum = acc;
      endcase
      acc_n     = {sum[AW-1], sum[AW-1:1]};
      q_n       = {sum[0], q_reg[OPW-1:1]};
      product_n = {acc_n[2*WIDTH-OPW-1:0], q_n};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_reg   <= '0;
         q_reg   <= '0;
         acc     <= '0;
         q_m1    <= 1'b0;
         count   <= '0;
         product <= '0;
      end else if (load) begin
         m_reg <= a_ext;
         q_reg <= b_ext;
         acc   <= '0;
         q_m1  <= 1'b0;
         count <= N_ITER;
      end else if (state == S_CALC) begin
         acc   <= acc_n;
         q_reg <= q_n;
         q_m1  <= q_reg[0];
         count <= count - CW'(1);
         if (count == CW'(1)) product <= product_n;
      end
   end

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Directed bench for booth_seq_mult_ctrl (WIDTH=8) with a queue of expected products.
module tb_booth_seq_mult_ctrl;

`ifdef BOOTH_UNSIGNED_EN
   localparam int N = 9;
`else
   localparam int N = 8;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  op_a = '0;
   logic [7:0]  op_b = '0;
   logic        result_ack = 1'b0;
   logic        busy, done;
   logic [15:0] product;

   int checks = 0;
   int errors = 0;
   logic [15:0] sb[$];
   logic [15:0] last_prod;

   booth_seq_mult_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .result_ack(result_ack), .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
`ifdef BOOTH_UNSIGNED_EN
      logic [15:0] p;
      p = a * b;
`else
      logic signed [15:0] p;
      p = $signed(a) * $signed(b);
`endif
      return p;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a one-cycle start; returns just after the accepting edge
   task automatic start_op(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b;
      sb.push_back(model(a, b));
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // cyc0 = edges already elapsed since the start edge
   task automatic wait_done(input string tag, input int cyc0);
      int cyc = cyc0;
      bit busy_ok = 1'b1;
      logic [15:0] exp;
      while (!done && cyc < 30) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"}, cyc, N);
      check({tag, "_busy_in_calc"}, busy_ok, 1);
      check({tag, "_busy_low_in_done"}, busy, 0);
      exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      check({tag, "_product"}, product, exp);
      last_prod = exp;
   endtask

   task automatic ack_result(input string tag);
      @(posedge clk); #1;
      check({tag, "_hold_done"}, done, 1);
      check({tag, "_hold_product"}, product, last_prod);
      @(negedge clk);
      result_ack = 1'b1;
      @(posedge clk); #1;
      result_ack = 1'b0;
      check({tag, "_ack_done_low"}, done, 0);
      check({tag, "_ack_product_kept"}, product, last_prod);
   endtask

   initial begin
      #12;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_product", product, 0);
      @(negedge clk);
      rst = 1'b1;

      // ack outside DONE has no effect
      result_ack = 1'b1;
      @(posedge clk); #1;
      result_ack = 1'b0;
      check("idle_ack_done", done, 0);

      start_op(8'd3, 8'd5);
      check("t0_busy", busy, 1);
      check("t0_done", done, 0);
      wait_done("mul_3x5", 0);
      check("mul_3x5_const", product, model(8'd3, 8'd5));
      ack_result("mul_3x5");

      start_op(8'hF9, 8'd6);   wait_done("mul_m7x6", 0);     ack_result("mul_m7x6");
      start_op(8'h80, 8'h80);  wait_done("mul_m128xm128", 0); ack_result("mul_m128xm128");
      start_op(8'h7F, 8'h80);  wait_done("mul_127xm128", 0); ack_result("mul_127xm128");
      start_op(8'h00, 8'hFF);  wait_done("mul_0xm1", 0);     ack_result("mul_0xm1");
      start_op(8'hFF, 8'hFF);  wait_done("mul_ffxff", 0);    ack_result("mul_ffxff");

      // start during CALC must be ignored
      start_op(8'd5, 8'hFD);
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      start = 1'b1; op_a = 8'd9; op_b = 8'd9;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("mid_start", 3);
      ack_result("mid_start");

      // async reset at CALC cycle 4 aborts immediately
      start_op(8'd7, 8'd7);
      repeat (3) begin @(posedge clk); #1; end
      check("abort_busy_before", busy, 1);
      rst = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_product", product, 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      check("abort_stays_idle", done, 0);
      @(negedge clk);
      rst = 1'b1;

      start_op(8'd10, 8'hF4); wait_done("after_reset", 0);

      // start and ack together in DONE: start wins
      @(negedge clk);
      start = 1'b1; result_ack = 1'b1; op_a = 8'd2; op_b = 8'd2;
      sb.push_back(model(8'd2, 8'd2));
      @(posedge clk); #1;
      start = 1'b0; result_ack = 1'b0;
      check("restart_done_low", done, 0);
      check("restart_busy", busy, 1);
      wait_done("restart_2x2", 0);
      ack_result("restart_2x2");

      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL global_timeout observed=running expected=finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
